// File: rtl/sprite_cmd_pkg.sv
// Shared definitions for the sprite command queue.
// Command word layout, special info codes and FSM states.
package sprite_cmd_pkg;

  localparam int ID_LSB    = 26;
  localparam int CHILD_LSB = 21;
  localparam int INFO_LSB  = 17;
  localparam int TYPE_LSB  = 14;
  localparam int SEL_BIT   = 13;
  localparam int MSG_LSB   = 0;

  localparam logic [3:0]  INFO_SWAP   = 4'hF;
  localparam logic [3:0]  INFO_UPDATE = 4'h1;
  localparam logic [31:0] IDLE_WORD   = 32'h0;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_HOLD_SWAP = 2'd2
  } state_e;

  function automatic logic is_swap(input logic [31:0] w);
    return w[INFO_LSB +: 4] == INFO_SWAP;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Command FIFO with registered head word.
// Full test uses the count before any same-cycle pop.
module cmd_fifo #(
  parameter int DEPTH = 16,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [31:0]   wdata,
  output logic          push_ok,
  output logic [31:0]   head,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   head_q, head_d;
  logic          do_pop;

  assign push_ok = push && (cnt_q < CW'(DEPTH));
  assign do_pop  = pop && (cnt_q != '0);
  assign head    = head_q;
  assign count   = cnt_q;

  // next pointers, count and head; head refills from memory or bypass
  always_comb begin
    wr_d   = wr_q;
    rd_d   = rd_q;
    head_d = head_q;
    if (push_ok) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    cnt_d = cnt_q + CW'(push_ok) - CW'(do_pop);
    if (do_pop) begin
      if (cnt_q == CW'(1)) head_d = wdata;
      else                 head_d = mem_q[rd_q + AW'(1)];
    end else if (cnt_q == '0) begin
      head_d = wdata;
    end
  end

  // storage array, data needs no reset
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= wdata;
  end

  // pointer, count and head registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_q   <= '0;
      rd_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
    end
  end

endmodule

// File: rtl/sprite_cmd_queue.sv
// Buffers HPS sprite commands and replays them on the shared bus.
// Swap commands are held until the vblank strobe.
module sprite_cmd_queue
  import sprite_cmd_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int VBLANK_LINE = 480
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] writedata,
  input  logic        write,
  input  logic        read,
  input  logic        chipselect,
  input  logic        address,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  output logic [31:0] readdata,
  output logic [31:0] cmd_out,
  output logic        front_buffer
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic          push_req, status_rd, cmd_rd;
  logic          push_ok, pop;
  logic [31:0]   head;
  logic [CW-1:0] count;

  state_e        state_q, state_d;
  logic [31:0]   cmd_q, cmd_d;
  logic [31:0]   rdata_q, rdata_d;
  logic          front_q, front_d;
  logic          ovf_q, ovf_d;
  logic          vblank, swap_pending, last_pop;

  assign push_req  = chipselect && write && !address;
  assign status_rd = chipselect && read && address;
  assign cmd_rd    = chipselect && read && !address;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .CW    (CW)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push_req),
    .pop     (pop),
    .wdata   (writedata),
    .push_ok (push_ok),
    .head    (head),
    .count   (count)
  );

  assign vblank = (hcount == 10'd0) && (vcount == 10'(VBLANK_LINE));
  assign swap_pending = (state_q == ST_HOLD_SWAP);
  assign last_pop = (count == CW'(1)) && !push_ok;

  // issue FSM: drain in order, park on a swap until vblank
  always_comb begin
    state_d = state_q;
    cmd_d   = IDLE_WORD;
    front_d = front_q;
    pop     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (count != '0) state_d = ST_ISSUE;
      end
      ST_ISSUE: begin
        if (count == '0) begin
          state_d = ST_IDLE;
        end else if (is_swap(head)) begin
          state_d = ST_HOLD_SWAP;
        end else begin
          pop   = 1'b1;
          cmd_d = head;
          if (last_pop) state_d = ST_IDLE;
        end
      end
      ST_HOLD_SWAP: begin
        if (vblank) begin
          pop     = 1'b1;
          cmd_d   = head;
          front_d = head[SEL_BIT];
          state_d = last_pop ? ST_IDLE : ST_ISSUE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // sticky overflow and registered status readback
  always_comb begin
    ovf_d   = (ovf_q && !status_rd) || (push_req && !push_ok);
    rdata_d = rdata_q;
    if (status_rd)
      rdata_d = {16'h0, ovf_q, swap_pending, front_q,
                 8'h0, 5'(count)};
    else if (cmd_rd)
      rdata_d = '0;
  end

  // state, bus, status and front buffer registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cmd_q   <= IDLE_WORD;
      rdata_q <= '0;
      front_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      rdata_q <= rdata_d;
      front_q <= front_d;
      ovf_q   <= ovf_d;
    end
  end

  assign readdata     = rdata_q;
  assign cmd_out      = cmd_q;
  assign front_buffer = front_q;

endmodule

// File: tb/tb_sprite_cmd_queue.sv
// Scoreboard bench for sprite_cmd_queue.
// Expected bus words carry the cycle they must appear in.
module tb_sprite_cmd_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] writedata;
  logic        write, read, chipselect, address;
  logic [9:0]  hcount, vcount;
  logic [31:0] readdata, cmd_out;
  logic        front_buffer;

  typedef struct {
    logic [31:0] w;
    int          at;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  sprite_cmd_queue #(.DEPTH(16), .VBLANK_LINE(480)) dut (
    .clk          (clk),
    .reset        (reset),
    .writedata    (writedata),
    .write        (write),
    .read         (read),
    .chipselect   (chipselect),
    .address      (address),
    .hcount       (hcount),
    .vcount       (vcount),
    .readdata     (readdata),
    .cmd_out      (cmd_out),
    .front_buffer (front_buffer)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [3:0] info,
                                     input logic sel,
                                     input logic [12:0] msg,
                                     input logic [5:0] id);
    return {id, 5'd0, info, 3'd0, sel, msg};
  endfunction

  task automatic idle_in();
    chipselect = 0; write = 0; read = 0; address = 0;
    writedata = 0; hcount = 10'd5; vcount = 10'd100;
  endtask

  task automatic push_in(input logic [31:0] w);
    chipselect = 1; write = 1; address = 0; writedata = w;
  endtask

  task automatic stat_in();
    chipselect = 1; read = 1; address = 1;
  endtask

  task automatic strobe_in();
    hcount = 10'd0; vcount = 10'd480;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic test_reset();
    idle_in();
    reset = 1;
    step();
    step();
    checks++;
    if (cmd_out !== 32'h0) begin
      errors++;
      $display("FAIL rst_cmd got %h exp 00000000", cmd_out);
    end
    checks++;
    if (readdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_rdata got %h exp 00000000", readdata);
    end
    checks++;
    if (front_buffer !== 1'b0) begin
      errors++;
      $display("FAIL rst_front got %b exp 0", front_buffer);
    end
    reset = 0;
    stat_in();
    step();
    idle_in();
    checks++;
    if (readdata !== 32'h0) begin
      errors++;
      $display("FAIL rst_status got %h exp 00000000", readdata);
    end
  endtask

  task automatic test_burst();
    logic [31:0] w [3];
    w[0] = mk(4'h1, 1'b0, 13'h011, 6'd1);
    w[1] = mk(4'h1, 1'b0, 13'h022, 6'd2);
    w[2] = mk(4'h1, 1'b1, 13'h033, 6'd3);
    for (int i = 0; i < 8; i++) begin
      idle_in();
      if (i < 3) begin
        push_in(w[i]);
        sb.push_back('{w[i], cyc + 3});
      end
      step();
      checks++;
      if (sb.size() != 0 && sb[0].at == cyc) begin
        if (cmd_out !== sb[0].w) begin
          errors++;
          $display("FAIL burst_bus c%0d got %h exp %h", cyc, cmd_out, sb[0].w);
        end
        void'(sb.pop_front());
      end else if (cmd_out !== 32'h0) begin
        errors++;
        $display("FAIL burst_idle c%0d got %h exp 00000000", cyc, cmd_out);
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL burst_left got %0d exp 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_swap_hold();
    logic [31:0] u, s, v;
    u = mk(4'h1, 1'b0, 13'h0a1, 6'd5);
    s = mk(4'hF, 1'b1, 13'h000, 6'd5);
    v = mk(4'h1, 1'b0, 13'h0a2, 6'd6);
    for (int i = 0; i < 18; i++) begin
      idle_in();
      if (i == 0) begin push_in(u); sb.push_back('{u, cyc + 3}); end
      if (i == 1) push_in(s);
      if (i == 2) push_in(v);
      if (i == 8 || i == 14) stat_in();
      if (i == 15) begin chipselect = 1; read = 1; address = 0; end
      if (i == 10) begin
        strobe_in();
        sb.push_back('{s, cyc + 1});
        sb.push_back('{v, cyc + 2});
      end
      step();
      checks++;
      if (sb.size() != 0 && sb[0].at == cyc) begin
        if (cmd_out !== sb[0].w) begin
          errors++;
          $display("FAIL swap_bus c%0d got %h exp %h", cyc, cmd_out, sb[0].w);
        end
        void'(sb.pop_front());
      end else if (cmd_out !== 32'h0) begin
        errors++;
        $display("FAIL swap_idle c%0d got %h exp 00000000", cyc, cmd_out);
      end
      if (i == 8) begin
        checks++;
        if (readdata !== 32'h0000_4002) begin
          errors++;
          $display("FAIL swap_held_status got %h exp 00004002", readdata);
        end
      end
      if (i == 10) begin
        checks++;
        if (front_buffer !== 1'b1) begin
          errors++;
          $display("FAIL swap_front got %b exp 1", front_buffer);
        end
      end
      if (i == 14) begin
        checks++;
        if (readdata !== 32'h0000_2000) begin
          errors++;
          $display("FAIL swap_done_status got %h exp 00002000", readdata);
        end
      end
      if (i == 15) begin
        checks++;
        if (readdata !== 32'h0) begin
          errors++;
          $display("FAIL addr0_read got %h exp 00000000", readdata);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL swap_left got %0d exp 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_overflow();
    logic [31:0] s, x;
    s = mk(4'hF, 1'b0, 13'h000, 6'd4);
    x = mk(4'h1, 1'b0, 13'h1abc, 6'd4);
    for (int i = 0; i < 41; i++) begin
      idle_in();
      if (i == 0) push_in(s);
      if (i >= 1 && i <= 16) push_in(mk(4'h1, 1'b0, 13'(i), 6'd4));
      if (i == 18 || i == 19 || i == 22) stat_in();
      if (i == 21) begin
        strobe_in();
        push_in(x);
        sb.push_back('{s, cyc + 1});
        for (int j = 0; j < 15; j++)
          sb.push_back('{mk(4'h1, 1'b0, 13'(j + 1), 6'd4), cyc + 2 + j});
      end
      step();
      checks++;
      if (sb.size() != 0 && sb[0].at == cyc) begin
        if (cmd_out !== sb[0].w) begin
          errors++;
          $display("FAIL ovf_bus c%0d got %h exp %h", cyc, cmd_out, sb[0].w);
        end
        void'(sb.pop_front());
      end else if (cmd_out !== 32'h0) begin
        errors++;
        $display("FAIL ovf_idle c%0d got %h exp 00000000", cyc, cmd_out);
      end
      if (i == 18) begin
        checks++;
        if (readdata !== 32'h0000_E010) begin
          errors++;
          $display("FAIL full_status got %h exp 0000e010", readdata);
        end
      end
      if (i == 19) begin
        checks++;
        if (readdata !== 32'h0000_6010) begin
          errors++;
          $display("FAIL ovf_clear got %h exp 00006010", readdata);
        end
      end
      if (i == 21) begin
        checks++;
        if (front_buffer !== 1'b0) begin
          errors++;
          $display("FAIL ovf_front got %b exp 0", front_buffer);
        end
      end
      if (i == 22) begin
        checks++;
        if (readdata !== 32'h0000_800F) begin
          errors++;
          $display("FAIL push_pop_full got %h exp 0000800f", readdata);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL ovf_left got %0d exp 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_two_swaps();
    logic [31:0] s3, s4, u2;
    s3 = mk(4'hF, 1'b1, 13'h000, 6'd7);
    s4 = mk(4'hF, 1'b0, 13'h000, 6'd8);
    u2 = mk(4'h1, 1'b0, 13'h055, 6'd9);
    for (int i = 0; i < 27; i++) begin
      idle_in();
      if (i == 0) push_in(s3);
      if (i == 1) push_in(s4);
      if (i == 2) push_in(u2);
      if (i == 10) begin strobe_in(); sb.push_back('{s3, cyc + 1}); end
      if (i == 12) begin hcount = 10'd1; vcount = 10'd480; end
      if (i == 15) stat_in();
      if (i == 20) begin
        strobe_in();
        sb.push_back('{s4, cyc + 1});
        sb.push_back('{u2, cyc + 2});
      end
      step();
      checks++;
      if (sb.size() != 0 && sb[0].at == cyc) begin
        if (cmd_out !== sb[0].w) begin
          errors++;
          $display("FAIL two_bus c%0d got %h exp %h", cyc, cmd_out, sb[0].w);
        end
        void'(sb.pop_front());
      end else if (cmd_out !== 32'h0) begin
        errors++;
        $display("FAIL two_idle c%0d got %h exp 00000000", cyc, cmd_out);
      end
      if (i == 10 || i == 20) begin
        checks++;
        if (front_buffer !== (i == 10)) begin
          errors++;
          $display("FAIL two_front c%0d got %b exp %b", cyc, front_buffer, i == 10);
        end
      end
      if (i == 15) begin
        checks++;
        if (readdata !== 32'h0000_6002) begin
          errors++;
          $display("FAIL two_status got %h exp 00006002", readdata);
        end
      end
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL two_left got %0d exp 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic test_reset_mid();
    logic [31:0] sa, sbw;
    sa  = mk(4'hF, 1'b1, 13'h000, 6'd10);
    sbw = mk(4'hF, 1'b0, 13'h000, 6'd11);
    for (int i = 0; i < 41; i++) begin
      idle_in();
      reset = (i == 22);
      if (i == 0) push_in(sa);
      if (i == 6) begin strobe_in(); sb.push_back('{sa, cyc + 1}); end
      if (i == 8) push_in(sbw);
      if (i >= 9 && i <= 13) push_in(mk(4'h1, 1'b0, 13'(i), 6'd12));
      if (i == 20 || i == 23) stat_in();
      if (i == 26 || i == 32) strobe_in();
      step();
      checks++;
      if (sb.size() != 0 && sb[0].at == cyc) begin
        if (cmd_out !== sb[0].w) begin
          errors++;
          $display("FAIL rmid_bus c%0d got %h exp %h", cyc, cmd_out, sb[0].w);
        end
        void'(sb.pop_front());
      end else if (cmd_out !== 32'h0) begin
        errors++;
        $display("FAIL rmid_idle c%0d got %h exp 00000000", cyc, cmd_out);
      end
      if (i == 6 || i == 22) begin
        checks++;
        if (front_buffer !== (i == 6)) begin
          errors++;
          $display("FAIL rmid_front c%0d got %b exp %b", cyc, front_buffer, i == 6);
        end
      end
      if (i == 20) begin
        checks++;
        if (readdata !== 32'h0000_6006) begin
          errors++;
          $display("FAIL rmid_held got %h exp 00006006", readdata);
        end
      end
      if (i == 22 || i == 23) begin
        checks++;
        if (readdata !== 32'h0) begin
          errors++;
          $display("FAIL rmid_status c%0d got %h exp 00000000", cyc, readdata);
        end
      end
    end
    reset = 0;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL rmid_left got %0d exp 0", sb.size());
    end
    sb.delete();
  endtask

  initial begin
    reset = 1;
    idle_in();
    test_reset();
    test_burst();
    test_swap_hold();
    test_overflow();
    test_two_swaps();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
